// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers:
// occupancy-encoded state type and the ID/EXE payload field layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // Control enables live in the low bits so bubbles can be masked cheaply.
  localparam int CTRL_W        = 5;
  localparam int OFF_S         = 0;
  localparam int OFF_B         = 1;
  localparam int OFF_MEM_W_EN  = 2;
  localparam int OFF_MEM_R_EN  = 3;
  localparam int OFF_WB_EN     = 4;
  localparam int OFF_EXE_CMD   = 5;
  localparam int OFF_IMM       = 9;
  localparam int OFF_SHIFT_OP  = 10;
  localparam int OFF_DEST      = 22;
  localparam int OFF_SRC1      = 26;
  localparam int OFF_SRC2      = 30;
  localparam int OFF_VAL_RN    = 34;
  localparam int OFF_VAL_RM    = 66;
  localparam int OFF_PC        = 98;
  localparam int OFF_SIMM24    = 130;
  localparam int OFF_SR_C      = 154;
  localparam int IDEX_W        = 155;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// One valid/ready/data channel between pipeline stages.
// Contract: a transfer happens on a rising edge where valid & ready are both 1;
// the master holds valid and data stable until that transfer, and ready never
// depends combinationally on valid.
interface pipe_stage_reg_if #(
  parameter int W = 155
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One storage slot of the stage: a valid flag plus a payload register.
module pipe_slot #(
  parameter int W = 155
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;

  // load wins over clear so a slot can be drained and refilled in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic two-entry pipeline register with flush, bubble masking of the
// control enables and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = IDEX_W,
  parameter int CTRL_W    = pipe_pkg::CTRL_W,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_reg_if.slave      up,
  pipe_stage_reg_if.master     dn,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output pipe_state_e          state_dbg_o
);
  pipe_state_e          state_q, state_d;
  logic                 main_valid, skid_valid;
  logic [PAYLOAD_W-1:0] main_data, skid_data, main_d;
  logic                 main_load, main_from_skid, main_clr;
  logic                 skid_load, skid_clr;
  logic                 in_fire, out_fire;
  logic [CNT_W-1:0]     stall_q;

  // in_ready comes straight from the skid valid flop: no out_ready path.
  assign up.ready = ~skid_valid;
  assign in_fire  = up.valid & ~skid_valid;
  assign out_fire = main_valid & dn.ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (out_fire && in_fire) begin
            main_load = 1'b1;
          end else if (out_fire) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end else if (in_fire) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_data : up.data;

  pipe_slot #(.W(PAYLOAD_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (main_clr),
    .d_i     (main_d),
    .valid_o (main_valid),
    .data_o  (main_data)
  );

  pipe_slot #(.W(PAYLOAD_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clr),
    .d_i     (up.data),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );

  always_comb begin
    dn.data = main_data;
    if (!main_valid) dn.data[CTRL_W-1:0] = '0;
  end
  assign dn.valid = main_valid;

  // Flush does not touch the counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (main_valid && !dn.ready && !(&stall_q)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt   = stall_q;
  assign occupancy   = state_q;
  assign state_dbg_o = state_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random stimulus for pipe_stage_reg, checked against a
// queue-based model of the two-entry FIFO stage and its stall counters.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int PW = 155;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [PW-1:0] in_data = '0;

  logic [1:0]  occ_a, occ_b;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;
  pipe_state_e st_a, st_b;

  pipe_stage_reg_if #(.W(PW)) up_a ();
  pipe_stage_reg_if #(.W(PW)) dn_a ();
  pipe_stage_reg_if #(.W(PW)) up_b ();
  pipe_stage_reg_if #(.W(PW)) dn_b ();

  assign up_a.valid = in_valid;
  assign up_a.data  = in_data;
  assign dn_a.ready = out_ready;
  assign up_b.valid = in_valid;
  assign up_b.data  = in_data;
  assign dn_b.ready = out_ready;

  pipe_stage_reg #(.PAYLOAD_W(PW), .CTRL_W(5), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .up(up_a), .dn(dn_a),
    .occupancy(occ_a), .stall_cnt(stall_a), .state_dbg_o(st_a)
  );

  pipe_stage_reg #(.PAYLOAD_W(PW), .CTRL_W(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .up(up_b), .dn(dn_b),
    .occupancy(occ_b), .stall_cnt(stall_b), .state_dbg_o(st_b)
  );

  always #5 clk = ~clk;

  // Reference model: entries in FIFO order, stall counts as plain integers.
  logic [PW-1:0] mq[$];
  int cnt_a = 0;
  int cnt_b = 0;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r_st, input logic fl, input logic v,
                            input logic [PW-1:0] d, input logic rdy);
    bit in_f, out_f;
    if (r_st) begin
      mq.delete();
      cnt_a = 0;
      cnt_b = 0;
      return;
    end
    if (mq.size() > 0 && !rdy) begin
      if (cnt_a < 65535) cnt_a++;
      if (cnt_b < 15) cnt_b++;
    end
    if (fl) begin
      mq.delete();
      return;
    end
    in_f  = v && (mq.size() < 2);
    out_f = (mq.size() > 0) && rdy;
    if (out_f) void'(mq.pop_front());
    if (in_f) mq.push_back(d);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/out_valid"}, 160'(dn_a.valid), 160'(mq.size() > 0));
    chk({tag, "/in_ready"}, 160'(up_a.ready), 160'(mq.size() < 2));
    chk({tag, "/occupancy"}, 160'(occ_a), 160'(mq.size()));
    chk({tag, "/state_dbg"}, 160'(st_a), 160'(mq.size()));
    if (mq.size() > 0) chk({tag, "/out_data"}, 160'(dn_a.data), 160'(mq[0]));
    else               chk({tag, "/bubble_ctrl"}, 160'(dn_a.data[4:0]), 160'(0));
    chk({tag, "/stall16"}, 160'(stall_a), 160'(cnt_a));
    chk({tag, "/stall4"}, 160'(stall_b), 160'(cnt_b));
    chk({tag, "/b_valid"}, 160'(dn_b.valid), 160'(mq.size() > 0));
    chk({tag, "/b_occ"}, 160'(occ_b), 160'(mq.size()));
  endtask

  task automatic step(input string tag, input logic r_st, input logic fl, input logic v,
                      input logic [PW-1:0] d, input logic rdy);
    rst = r_st;
    flush = fl;
    in_valid = v;
    in_data = d;
    out_ready = rdy;
    @(posedge clk);
    model_edge(r_st, fl, v, d, rdy);
    @(negedge clk);
    check_all(tag);
  endtask

  function automatic logic [PW-1:0] rand_payload();
    logic [PW-1:0] r = '0;
    for (int k = 0; k < 5; k++) r = {r[PW-33:0], 32'($urandom())};
    return r;
  endfunction

  initial begin
    // Reset: all outputs and the whole payload register at zero.
    step("reset0", 1, 0, 0, '0, 0);
    step("reset1", 1, 0, 0, '0, 0);
    chk("reset/out_data_all", 160'(dn_a.data), 160'(0));

    // Single entry, one-cycle latency.
    step("single", 0, 0, 1, PW'(8'hA5), 1);
    chk("single/data_a5", 160'(dn_a.data), 160'(8'hA5));
    step("single_drain", 0, 0, 0, '0, 1);

    // Back-to-back stream with the sink always ready.
    for (int i = 1; i <= 8; i++) step("stream", 0, 0, 1, PW'(i), 1);
    step("stream_drain", 0, 0, 0, '0, 1);
    chk("stream/no_stall", 160'(stall_a), 160'(0));

    // Backpressure: two accepted, third held upstream, then released in order.
    step("bp_push1", 0, 0, 1, PW'(1), 0);
    step("bp_push2", 0, 0, 1, PW'(2), 0);
    chk("bp/in_ready_low", 160'(up_a.ready), 160'(0));
    step("bp_hold3", 0, 0, 1, PW'(3), 0);
    step("bp_hold3b", 0, 0, 1, PW'(3), 0);
    step("bp_rel1", 0, 0, 1, PW'(3), 1);
    chk("bp/second_out", 160'(dn_a.data), 160'(2));
    step("bp_rel2", 0, 0, 1, PW'(3), 1);
    chk("bp/third_out", 160'(dn_a.data), 160'(3));
    step("bp_rel3", 0, 0, 0, '0, 1);

    // Flush while full, with a payload presented that must be discarded.
    step("fl_push1", 0, 0, 1, PW'(1), 0);
    step("fl_push2", 0, 0, 1, PW'(2), 0);
    step("flush", 0, 1, 1, PW'(9), 0);
    chk("flush/ctrl_zero", 160'(dn_a.data[4:0]), 160'(0));
    chk("flush/in_ready", 160'(up_a.ready), 160'(1));
    for (int i = 0; i < 3; i++) step("post_flush", 0, 0, 0, PW'(9), 1);

    // Long stall: the 4-bit counter saturates at 15.
    step("sat_push", 0, 0, 1, PW'(5), 0);
    for (int i = 0; i < 20; i++) step("sat", 0, 0, 0, '0, 0);
    chk("sat/stall4_15", 160'(stall_b), 160'(15));
    step("sat_drain", 0, 0, 0, '0, 1);

    // Reset while full with stall count 7, then first accept after reset.
    step("rst_pre", 1, 0, 0, '0, 0);
    step("rst_push1", 0, 0, 1, PW'(1), 0);
    step("rst_push2", 0, 0, 1, PW'(2), 0);
    for (int i = 0; i < 6; i++) step("rst_stall", 0, 0, 0, '0, 0);
    chk("rst/stall_7", 160'(stall_a), 160'(7));
    step("rst_mid", 1, 0, 1, PW'(4), 0);
    chk("rst/stall_zero", 160'(stall_a), 160'(0));
    step("rst_accept", 0, 0, 1, PW'(8'h77), 1);
    chk("rst/accept_data", 160'(dn_a.data), 160'(8'h77));

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), rand_payload(), ($urandom_range(0, 3) != 0));
    end

    // Random with a mostly stalled sink to exercise the full state.
    for (int i = 0; i < 300; i++) begin
      step("rand_bp", 1'b0, ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 3) != 0), rand_payload(), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
